// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Parametrised UART receiver with configurable frame format,
//               false-start rejection, per-frame error flags and a show-ahead
//               valid/ready output backed by a small receive buffer.
//               Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise
//               a single holding register is used.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int CLOCK_BAUD_RATIO = 400,
  parameter int BIT_WIDTH        = 8,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic                 out_parity_err,
  output logic                 out_frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int c_tmr_w = $clog2(CLOCK_BAUD_RATIO);
  localparam int c_idx_w = $clog2(BIT_WIDTH + 1);
  localparam int c_ent_w = BIT_WIDTH + 2;
  localparam logic [c_tmr_w-1:0] c_half      = c_tmr_w'(CLOCK_BAUD_RATIO / 2 - 1);
  localparam logic [c_tmr_w-1:0] c_full      = c_tmr_w'(CLOCK_BAUD_RATIO - 1);
  localparam logic [c_idx_w-1:0] c_last_data = c_idx_w'(BIT_WIDTH - 1);
  localparam logic [c_idx_w-1:0] c_last_stop = c_idx_w'(STOP_BITS - 1);

  // Reject unsupported parameter sets at elaboration. The depth rule is
  // enforced in both builds so one parameter set is valid either way.
  if (CLOCK_BAUD_RATIO < 8 || (CLOCK_BAUD_RATIO % 2) != 0) begin : g_chk_ratio
    $error("CLOCK_BAUD_RATIO must be >= 8 and even");
  end
  if (BIT_WIDTH < 5 || BIT_WIDTH > 9) begin : g_chk_width
    $error("BIT_WIDTH must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  logic                 r_sync1, r_sync2, r_prev;
  logic [c_tmr_w-1:0]   r_tmr;
  logic [c_idx_w-1:0]   r_idx;
  logic [BIT_WIDTH-1:0] r_shift;
  logic                 r_perr, r_ferr, r_busy, r_overrun;
  logic                 w_fall, w_tick, w_par_x, w_par_err;
  logic                 w_push, w_pop, w_full, w_wr;
  logic [c_ent_w-1:0]   w_entry, w_head;

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_fall    = r_prev & ~r_sync2;
  assign w_tick    = (r_tmr == '0);
  // Parity check covers the received data plus the parity bit being sampled
  assign w_par_x   = ^{r_shift, r_sync2};
  assign w_par_err = (PARITY == 2) ? ~w_par_x : w_par_x;

  // The push is combinational so the entry lands in the buffer on the edge
  // that ends the last stop sample; the frame flag includes that sample.
  assign w_push  = (r_state == S_STOP) && w_tick && (r_idx == c_last_stop);
  assign w_entry = {r_ferr | ~r_sync2, r_perr, r_shift};
  assign w_pop   = out_valid & out_ready;

  // Receiver FSM: mid-bit sampling driven by a reloading down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      if (r_state != S_IDLE && !w_tick) r_tmr <= r_tmr - 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state <= S_START;
            r_tmr   <= c_half;
            r_idx   <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_sync2) begin
              // Line back high at mid start bit: glitch, drop it
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_DATA;
              r_tmr   <= c_full;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_tmr   <= c_full;
            r_shift <= {r_sync2, r_shift[BIT_WIDTH-1:1]};
            if (r_idx == c_last_data) begin
              r_idx   <= '0;
              r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_tmr   <= c_full;
            r_perr  <= w_par_err;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_tmr <= c_full;
            if (!r_sync2) r_ferr <= 1'b1;
            if (r_idx == c_last_stop) begin
              r_idx   <= '0;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(FIFO_DEPTH);

  logic [c_ent_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr, r_wr_ptr;
  logic [c_ptr_w:0]   r_count;

  // A pop in the same cycle frees the slot for a push into a full FIFO
  assign w_full = (r_count == c_depth);
  assign w_wr   = w_push & (~w_full | w_pop);

  // Receive FIFO storage, pointers and overrun pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overrun <= w_push & w_full & ~w_pop;
    end
  end

  // Head slot only changes on pop or on a push while empty (wr == rd)
  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = (r_count != '0);
`else
  logic               r_valid;
  logic [c_ent_w-1:0] r_hold;

  assign w_full = r_valid;
  assign w_wr   = w_push & (~r_valid | w_pop);

  // Single holding register in place of the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_hold    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr) begin
        r_hold  <= w_entry;
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
      r_overrun <= w_push & w_full & ~w_pop;
    end
  end

  assign w_head    = r_hold;
  assign out_valid = r_valid;
`endif

  assign out_data       = w_head[BIT_WIDTH-1:0];
  assign out_parity_err = w_head[BIT_WIDTH];
  assign out_frame_err  = w_head[BIT_WIDTH+1];
  assign overrun        = r_overrun;
  assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed bench for uart_rx_fifo. dut0 is 8N1, dut1 is 8E1,
//               both at 16 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int R     = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx0 = 1'b1, rx1 = 1'b1;
  logic       rdy0 = 1'b1, rdy1 = 1'b1;
  logic       out_valid0, out_valid1, perr0, perr1, ferr0, ferr1;
  logic       overrun0, overrun1, busy0, busy1;
  logic [7:0] out_data0, out_data1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n0 = 0;

  uart_rx_fifo #(.CLOCK_BAUD_RATIO(R), .BIT_WIDTH(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .out_valid(out_valid0), .out_ready(rdy0),
    .out_data(out_data0), .out_parity_err(perr0), .out_frame_err(ferr0),
    .overrun(overrun0), .busy(busy0));

  uart_rx_fifo #(.CLOCK_BAUD_RATIO(R), .BIT_WIDTH(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .out_valid(out_valid1), .out_ready(rdy1),
    .out_data(out_data1), .out_parity_err(perr1), .out_frame_err(ferr1),
    .overrun(overrun1), .busy(busy1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Event recorder: edges of valid/busy, overrun pulses, accepted entries
  logic       v0_q = 1'b0, b0_q = 1'b0;
  int         rise0 = -1, fall0 = -1, brise0 = -1, bfall0 = -1;
  int         ovr_cyc0 = -1, ovr_cnt0 = 0;
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  always @(negedge clk) begin
    if (out_valid0 && !v0_q) rise0 = cyc;
    if (!out_valid0 && v0_q) fall0 = cyc;
    v0_q = out_valid0;
    if (busy0 && !b0_q) brise0 = cyc;
    if (!busy0 && b0_q) bfall0 = cyc;
    b0_q = busy0;
    if (overrun0) begin ovr_cnt0++; ovr_cyc0 = cyc; end
    if (out_valid0 && rdy0) q0.push_back({ferr0, perr0, out_data0});
    if (out_valid1 && rdy1) q1.push_back({ferr1, perr1, out_data1});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_rx(input int which, input logic b);
    if (which == 0) rx0 = b; else rx1 = b;
  endtask

  // One frame, start bit driven right after a posedge; n0 is that edge's cycle
  task automatic send_frame(input int which, input logic [7:0] data, input bit has_par,
                            input logic par_bit, input logic stop_bit);
    @(posedge clk); #1; set_rx(which, 1'b0); n0 = cyc;
    repeat (R - 1) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1; set_rx(which, data[i]);
      repeat (R - 1) @(posedge clk);
    end
    if (has_par) begin
      @(posedge clk); #1; set_rx(which, par_bit);
      repeat (R - 1) @(posedge clk);
    end
    @(posedge clk); #1; set_rx(which, stop_bit);
    repeat (R - 1) @(posedge clk);
    @(posedge clk); #1; set_rx(which, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (out_valid0 !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid0); end
    vectors++; if (out_data0 !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", out_data0); end
    vectors++; if (perr0 !== 1'b0) begin miscompares++; $display("FAIL reset_perr got %b want 0", perr0); end
    vectors++; if (ferr0 !== 1'b0) begin miscompares++; $display("FAIL reset_ferr got %b want 0", ferr0); end
    vectors++; if (overrun0 !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", overrun0); end
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy0); end
    vectors++; if (out_valid1 !== 1'b0) begin miscompares++; $display("FAIL reset_valid1 got %b want 0", out_valid1); end
    vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL reset_busy1 got %b want 0", busy1); end
  endtask

  // 0xA5 8N1: fall at n0+2 (D), busy at D+1, push at D+152, valid at D+153
  task automatic test_basic();
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    vectors++; if (rise0 - n0 !== 155) begin miscompares++; $display("FAIL basic_valid_rise got %0d want 155", rise0 - n0); end
    vectors++; if (fall0 - rise0 !== 1) begin miscompares++; $display("FAIL basic_valid_width got %0d want 1", fall0 - rise0); end
    vectors++; if (brise0 - n0 !== 3) begin miscompares++; $display("FAIL basic_busy_rise got %0d want 3", brise0 - n0); end
    vectors++; if (bfall0 - n0 !== 155) begin miscompares++; $display("FAIL basic_busy_fall got %0d want 155", bfall0 - n0); end
    vectors++; if (q0.size() !== 1) begin miscompares++; $display("FAIL basic_count got %0d want 1", q0.size()); end
    vectors++; if (q0[0] !== 10'h0A5) begin miscompares++; $display("FAIL basic_entry got %h want 0a5", q0[0]); end
  endtask

  task automatic test_parity();
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
    send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    vectors++; if (q1.size() !== 3) begin miscompares++; $display("FAIL parity_count got %0d want 3", q1.size()); end
    vectors++; if (q1[0] !== 10'h103) begin miscompares++; $display("FAIL parity_bad got %h want 103", q1[0]); end
    vectors++; if (q1[1] !== 10'h003) begin miscompares++; $display("FAIL parity_good got %h want 003", q1[1]); end
    vectors++; if (q1[2] !== 10'h007) begin miscompares++; $display("FAIL parity_odd_ones got %h want 007", q1[2]); end
  endtask

  // rx low for 4 cycles: start sample at D+8 sees 1, busy drops at D+9
  task automatic test_glitch();
    int sz, oc;
    sz = q0.size(); oc = ovr_cnt0;
    @(posedge clk); #1; rx0 = 1'b0; n0 = cyc;
    repeat (4) @(posedge clk);
    #1; rx0 = 1'b1;
    repeat (20) @(negedge clk);
    vectors++; if (brise0 - n0 !== 3) begin miscompares++; $display("FAIL glitch_busy_rise got %0d want 3", brise0 - n0); end
    vectors++; if (bfall0 - n0 !== 11) begin miscompares++; $display("FAIL glitch_busy_fall got %0d want 11", bfall0 - n0); end
    vectors++; if (q0.size() !== sz) begin miscompares++; $display("FAIL glitch_no_push got %0d want %0d", q0.size(), sz); end
    vectors++; if (ovr_cnt0 !== oc) begin miscompares++; $display("FAIL glitch_overrun got %0d want %0d", ovr_cnt0, oc); end
  endtask

  task automatic test_frame_err();
    int sz;
    sz = q0.size();
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    vectors++; if (q0.size() !== sz + 2) begin miscompares++; $display("FAIL ferr_count got %0d want %0d", q0.size(), sz + 2); end
    vectors++; if (q0[sz] !== 10'h23C) begin miscompares++; $display("FAIL ferr_entry got %h want 23c", q0[sz]); end
    vectors++; if (q0[sz+1] !== 10'h011) begin miscompares++; $display("FAIL ferr_next got %h want 011", q0[sz+1]); end
  endtask

  task automatic test_back_to_back();
    int sz;
    sz = q0.size();
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    vectors++; if (q0.size() !== sz + 2) begin miscompares++; $display("FAIL b2b_count got %0d want %0d", q0.size(), sz + 2); end
    vectors++; if (q0[sz] !== 10'h05A) begin miscompares++; $display("FAIL b2b_first got %h want 05a", q0[sz]); end
    vectors++; if (q0[sz+1] !== 10'h081) begin miscompares++; $display("FAIL b2b_second got %h want 081", q0[sz+1]); end
    vectors++; if (rise0 - n0 !== 155) begin miscompares++; $display("FAIL b2b_second_rise got %0d want 155", rise0 - n0); end
  endtask

  task automatic test_overrun();
    int sz, oc;
    @(posedge clk); #1; rdy0 = 1'b0;
    sz = q0.size(); oc = ovr_cnt0;
    for (int i = 1; i <= CAP + 1; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    vectors++; if (ovr_cnt0 - oc !== 1) begin miscompares++; $display("FAIL ovr_pulses got %0d want 1", ovr_cnt0 - oc); end
    vectors++; if (ovr_cyc0 - n0 !== 155) begin miscompares++; $display("FAIL ovr_timing got %0d want 155", ovr_cyc0 - n0); end
    vectors++; if (out_valid0 !== 1'b1) begin miscompares++; $display("FAIL ovr_valid got %b want 1", out_valid0); end
    vectors++; if (out_data0 !== 8'h01) begin miscompares++; $display("FAIL ovr_head got %h want 01", out_data0); end
    @(posedge clk); #1; rdy0 = 1'b1;
    repeat (CAP + 4) @(negedge clk);
    vectors++; if (q0.size() !== sz + CAP) begin miscompares++; $display("FAIL ovr_drain_count got %0d want %0d", q0.size(), sz + CAP); end
    for (int i = 0; i < CAP; i++) begin
      vectors++; if (q0[sz+i] !== {2'b00, 8'(i + 1)}) begin miscompares++; $display("FAIL ovr_order[%0d] got %h want %h", i, q0[sz+i], i + 1); end
    end
    vectors++; if (out_valid0 !== 1'b0) begin miscompares++; $display("FAIL ovr_empty got %b want 0", out_valid0); end

    // Refill, then pop in the very cycle the last frame is pushed
    @(posedge clk); #1; rdy0 = 1'b0;
    sz = q0.size(); oc = ovr_cnt0;
    for (int i = 1; i <= CAP; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1);
    fork
      send_frame(0, 8'(CAP + 1), 1'b0, 1'b0, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #1; rdy0 = 1'b1;
        @(posedge clk);
        #1; rdy0 = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    vectors++; if (ovr_cnt0 !== oc) begin miscompares++; $display("FAIL popush_overrun got %0d want %0d", ovr_cnt0, oc); end
    @(posedge clk); #1; rdy0 = 1'b1;
    repeat (CAP + 4) @(negedge clk);
    vectors++; if (q0.size() !== sz + CAP + 1) begin miscompares++; $display("FAIL popush_count got %0d want %0d", q0.size(), sz + CAP + 1); end
    for (int i = 0; i <= CAP; i++) begin
      vectors++; if (q0[sz+i] !== {2'b00, 8'(i + 1)}) begin miscompares++; $display("FAIL popush_order[%0d] got %h want %h", i, q0[sz+i], i + 1); end
    end
  endtask

  task automatic test_reset_midframe();
    @(posedge clk); #1; rdy0 = 1'b0;
    send_frame(0, 8'h77, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1; rx0 = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("FAIL midrst_busy_before got %b want 1", busy0); end
    vectors++; if (out_valid0 !== 1'b1) begin miscompares++; $display("FAIL midrst_valid_before got %b want 1", out_valid0); end
    rst_n = 1'b0;
    #1;
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", busy0); end
    vectors++; if (out_valid0 !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got %b want 0", out_valid0); end
    rx0 = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    vectors++; if (out_data0 !== 8'h00) begin miscompares++; $display("FAIL midrst_data got %h want 00", out_data0); end
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL midrst_idle got %b want 0", busy0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_overrun();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver that generalises the existing single-byte receiver. It adds configurable frame format (data bits, parity, stop bits), false-start rejection, per-frame error flags and a valid/ready output stream backed by a small receive FIFO. It sits between the asynchronous `rx` pin and any byte-stream consumer in the fabric.

## Interface
- `CLOCK_BAUD_RATIO`, 400: clk cycles per bit; must be ≥ 8 and even.
- `BIT_WIDTH`, 8: data bits per frame, 5–9, sent LSB first.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: entries; power of two, ≥ 2. Used only with `UART_RX_FIFO_EN`.
- `clk` input 1: sole clock, all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx` input 1: serial line, idle high, asynchronous to `clk`.
- `out_valid` output 1: head entry available.
- `out_ready` input 1: consumer accepts the head entry when `out_valid && out_ready`.
- `out_data` output BIT_WIDTH: head data.
- `out_parity_err` output 1: head frame failed its parity check; always 0 when PARITY = 0.
- `out_frame_err` output 1: head frame had a low stop bit.
- `overrun` output 1: one-cycle pulse when a completed frame is dropped.
- `busy` output 1: receiver FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer, then a third flop. `fall` = prev & !sync.
- FSM states and transitions:
  - IDLE → START on `fall`.
  - START waits CLOCK_BAUD_RATIO/2 cycles, then samples. Sample 1 means a false start and returns to IDLE with nothing pushed. Sample 0 goes to DATA.
  - DATA takes BIT_WIDTH samples, each CLOCK_BAUD_RATIO cycles apart, shifted in LSB first.
  - PARITY (only when PARITY ≠ 0) takes one sample. Error when XOR(data, parity bit) ≠ 0 for even parity, or = 0 for odd parity.
  - STOP takes STOP_BITS samples. Any sample of 0 sets frame_err.
  - After the last stop sample the FSM pushes the entry and goes to IDLE in the same cycle. The next `fall` is honoured immediately, so back-to-back frames are received.
- Bit timer: down-counter of width $clog2(CLOCK_BAUD_RATIO). It reloads on every sample. Bit index counter width is $clog2(BIT_WIDTH+1) and does not wrap.
- FIFO entry is {frame_err, parity_err, data}. Output is show-ahead: `out_*` reflect the head entry whenever `out_valid` = 1.
- Full FIFO at push time: the new frame is discarded, stored entries are untouched, and `overrun` pulses for 1 cycle.
- Push and pop in the same cycle while full: the pop frees a slot, the push is accepted, and no overrun occurs.
- Pop while empty is ignored.
- `out_data` and the error flags are don't-care when `out_valid` = 0 but are held stable. They change only on pop or push-into-empty.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_parity_err` 0, `out_frame_err` 0, `overrun` 0, `busy` 0. FSM is in IDLE, FIFO is empty, and all synchronizer flops are 1.
- `rst_n` asserted mid-frame aborts the frame and flushes the FIFO at once.
- Let cycle D be the cycle `fall` is high. `busy` is 1 from D+1.
- Data bit k is sampled at D + R/2 + (k+1)·R, where R = CLOCK_BAUD_RATIO.
- The last stop sample is at S = D + R/2 + (BIT_WIDTH + P + STOP_BITS)·R, where P = 1 if parity is used, else 0.
- The push happens at S. `out_valid` rises at S+1 if the FIFO was empty. `overrun` pulses at S+1.
- Pop latency: after a pop at cycle C, the next entry is presented at C+1 and `out_valid` is re-evaluated at C+1.

## Configuration
- `UART_RX_FIFO_EN` defined: FIFO of FIFO_DEPTH entries as described above.
- `UART_RX_FIFO_EN` undefined: a single holding register is used in place of the FIFO and FIFO_DEPTH is ignored.
  - Push into the full register drops the new frame and pulses `overrun`.
  - Simultaneous pop and push in the same cycle is accepted.
  - Port list and timing are identical in both builds.

## Test plan
- Reset: `rst_n` low with R = 16, 8N1, then release → all outputs 0, `busy` 0.
- Frame 0xA5, 8N1, R = 16, `out_ready` = 1 → `out_data` = 0xA5, both error flags 0, `out_valid` high exactly at D+153 for 1 cycle.
- PARITY = 1, frame 0x03 with parity bit 1 (wrong, even parity requires 0) → `out_parity_err` = 1. The same frame with parity bit 0 → `out_parity_err` = 0.
- Glitch: `rx` low for 4 cycles, R = 16 → no push, `busy` returns to 0 at D+9.
- Frame 0x3C with a low stop bit → `out_frame_err` = 1, `out_data` = 0x3C; a following frame 0x11 is received correctly.
- FIFO_DEPTH = 4, `out_ready` = 0, five frames 0x01–0x05 → `overrun` pulses once on the fifth. Pops then return 0x01–0x04 in order.
  - Repeat with `out_ready` pulsed in the push cycle → 0x05 is kept and no overrun occurs.
